mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single `mem` port between the instruction-fetch requester and the load/store unit (behind `data_memory`). It latches one request at a time, drives `mem_addr`/`mem_mask`/`mem_cmd`/`mem_write_data`/`mem_enable` from registers, waits for `mem_valid`, and returns a one-cycle completion pulse with the load data to the owning requester. It sits between the core's fetch/data paths and `mem`.

## Interface

Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; mask width is `DATA_W/8`.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `if_req`  in  1  fetch request; held until `if_valid`.
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req` is high.
- `if_valid`  out  1  one-cycle fetch completion pulse.
- `if_rdata`  out  DATA_W  fetched word; valid when `if_valid` is high.
- `dm_req`  in  1  data request; held until `dm_valid`.
- `dm_cmd`  in  1  0 = read (`MEM_CMD_READ`), 1 = write (`MEM_CMD_WRITE`).
- `dm_addr`  in  ADDR_W  data address.
- `dm_mask`  in  4  byte write mask.
- `dm_wdata`  in  DATA_W  store data.
- `dm_valid`  out  1  one-cycle data completion pulse; fires for reads and writes.
- `dm_rdata`  out  DATA_W  load data; valid when `dm_valid` is high.
- `mem_addr`  out  ADDR_W  to `mem`.
- `mem_mask`  out  4  to `mem`.
- `mem_enable`  out  1  to `mem`; held high for the whole transaction.
- `mem_cmd`  out  1  to `mem`.
- `mem_write_data`  out  DATA_W  to `mem`.
- `mem_load_data`  in  DATA_W  from `mem`.
- `mem_valid`  in  1  from `mem`; transaction complete.

## Operation

- FSM states: IDLE, BUSY, RESP.
- IDLE: when `if_req` or `dm_req` is sampled high, select an owner, latch its addr, mask, cmd and wdata into the `mem_*` registers, set `mem_enable`=1, and go to BUSY. If neither is high, stay in IDLE.
- Fetch transactions always issue with cmd=0, mask=4'b1111, wdata=0.
- BUSY: `mem_*` outputs are frozen. When `mem_valid` is sampled high, capture `mem_load_data` into the owner's rdata register, clear `mem_enable`, assert the owner's valid, and go to RESP.
- RESP: the valid pulse is visible for exactly this cycle. Requests are ignored. Next state is IDLE.
- Requester rule: deassert req on the edge that samples valid. A req still high in the following IDLE cycle is a new request.
- The non-owner's rdata register holds its previous value.
- Tie (both requests high in IDLE): the data port wins. See Configuration for the round-robin variant.
- `mem_valid` outside BUSY is ignored.

## Timing

- Reset (`reset_n`=0 at an edge): state=IDLE; all outputs 0 (`mem_enable`, `mem_cmd`, `mem_addr`, `mem_mask`, `mem_write_data`, `if_valid`, `dm_valid`, `if_rdata`, `dm_rdata`); round-robin pointer cleared.
- Reset mid-transaction abandons the transaction. No valid pulse is produced, and `mem_enable` is 0 the cycle after the reset edge.
- Request sampled at edge E: `mem_enable` rises after E. If `mem_valid` is high in the first BUSY cycle, valid is seen at E+2.
- General latency: valid appears 1 cycle after the edge that samples `mem_valid`.
- Back-to-back: issue-to-issue minimum is 3 cycles (BUSY, RESP, IDLE with `mem_valid` on the first BUSY cycle).
- `mem_enable` and `*_valid` are never high in the same cycle.

## Configuration

- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit last-owner register, reset to "fetch", updates on each grant.
  - On a tie, the port not granted last wins. Single requests are granted regardless of the pointer.
- Macro undefined: fixed priority, data over fetch, and no pointer register exists.

## Test plan

- Reset then single fetch: `if_addr`=0x14, `mem_valid` asserted 2 cycles into BUSY with `mem_load_data`=0x00000100 -> `mem_cmd`=0, `mem_mask`=4'hF, `if_valid` pulses once with `if_rdata`=0x00000100, `dm_valid` stays 0.
- Data write: `dm_cmd`=1, `dm_addr`=0x14, `dm_mask`=4'b0011, `dm_wdata`=0x0000FFFF -> `mem_*` outputs carry these values unchanged until `mem_valid`; `dm_valid` pulses 1 cycle later.
- Simultaneous `if_req`+`dm_req` held continuously, macro undefined -> grants go D,D,D… for as long as `dm_req` is re-raised. With `MEM_ARB_ROUND_ROBIN_EN` -> grants alternate D,F,D,F.
- Reset mid-BUSY: assert `reset_n`=0 for one edge while `mem_valid`=0 -> `mem_enable` is 0 next cycle, no valid pulse, and a later `mem_valid` is ignored.
- Stray `mem_valid` in IDLE with no requests -> no valid pulses and state remains IDLE.
- Minimum latency: `mem_valid` held at 1 -> valid pulse 2 cycles after the request edge, and the 3-cycle issue period is met.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one mem port between fetch and data requesters.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate ties instead of always favouring data.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_valid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_cmd,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W/8-1:0]   dm_mask,
    input  logic [DATA_W-1:0]     dm_wdata,
    output logic                  dm_valid,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_mask,
    output logic                  mem_enable,
    output logic                  mem_cmd,
    output logic [DATA_W-1:0]     mem_write_data,
    input  logic [DATA_W-1:0]     mem_load_data,
    input  logic                  mem_valid
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0] state;
    logic       owner_dm;
    logic       grant_dm;
    logic       any_req;

    assign any_req = if_req || dm_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // last_dm = 0 means fetch owned the previous grant, so data wins the next tie
    logic last_dm;

    always_comb grant_dm = dm_req && (!if_req || !last_dm);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_dm <= 1'b0;
        end else if (state == ST_IDLE && any_req) begin
            last_dm <= grant_dm;
        end
    end
`else
    assign grant_dm = dm_req;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            owner_dm       <= 1'b0;
            mem_enable     <= 1'b0;
            mem_cmd        <= 1'b0;
            mem_addr       <= '0;
            mem_mask       <= '0;
            mem_write_data <= '0;
            if_valid       <= 1'b0;
            dm_valid       <= 1'b0;
            if_rdata       <= '0;
            dm_rdata       <= '0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_dm   <= grant_dm;
                        mem_enable <= 1'b1;
                        state      <= ST_BUSY;
                        if (grant_dm) begin
                            mem_cmd        <= dm_cmd;
                            mem_addr       <= dm_addr;
                            mem_mask       <= dm_mask;
                            mem_write_data <= dm_wdata;
                        end else begin
                            mem_cmd        <= 1'b0;
                            mem_addr       <= if_addr;
                            mem_mask       <= '1;
                            mem_write_data <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_valid) begin
                        mem_enable <= 1'b0;
                        state      <= ST_RESP;
                        if (owner_dm) begin
                            dm_rdata <= mem_load_data;
                            dm_valid <= 1'b1;
                        end else begin
                            if_rdata <= mem_load_data;
                            if_valid <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter.
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, if_valid, dm_req, dm_cmd, dm_valid;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_mask, mem_mask;
    logic [31:0] mem_addr, mem_write_data, mem_load_data;
    logic        mem_enable, mem_cmd, mem_valid;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_cmd(dm_cmd), .dm_addr(dm_addr), .dm_mask(dm_mask),
        .dm_wdata(dm_wdata), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_enable(mem_enable),
        .mem_cmd(mem_cmd), .mem_write_data(mem_write_data),
        .mem_load_data(mem_load_data), .mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requester state as seen by the reference model
    bit          f_pend = 0, d_pend = 0;
    int          f_raise, d_raise;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic        d_cmd;
    logic [3:0]  d_mask;

    // Reference model state
    bit          model_last_dm = 0;
    logic [31:0] model_if_rd = '0, model_dm_rd = '0;

    typedef struct {
        bit          port_dm;
        logic [31:0] rdata;
        int          due;
    } exp_t;
    exp_t sb[$];

    bit          resp_en = 0, mon_en = 0, chk_period = 0, use_force_data = 0;
    int          force_lat = -1;
    logic [31:0] force_data;
    int          last_grant = -1;

    // Memory responder: predicts the grant, checks the issued command, answers after a latency
    initial begin : responder
        bit          in_tx;
        bit          own_dm, ie, de;
        int          wait_n;
        logic [31:0] e_addr, e_wd, rd;
        logic [3:0]  e_mask;
        logic        e_cmd;
        exp_t        e;
        in_tx = 0;
        mem_valid = 0;
        mem_load_data = '0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                if (!in_tx) begin
                    mem_valid = 1'b0;
                    if (mem_enable === 1'b1) begin
                        ie = f_pend && (f_raise < cyc);
                        de = d_pend && (d_raise < cyc);
                        check("grant_has_request", ie || de, 1);
                        own_dm = de && (!ie || !(RR && model_last_dm));
                        model_last_dm = own_dm;
                        if (own_dm) begin
                            e_cmd = d_cmd; e_addr = d_addr; e_mask = d_mask; e_wd = d_wdata;
                        end else begin
                            e_cmd = 1'b0; e_addr = f_addr; e_mask = 4'hF; e_wd = '0;
                        end
                        if (chk_period && last_grant >= 0) check("issue_period", cyc - last_grant, 3);
                        last_grant = cyc;
                        wait_n = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
                        in_tx = 1;
                    end else if ($urandom_range(0, 3) == 0) begin
                        mem_valid = 1'b1;
                        mem_load_data = $urandom;
                    end
                end
                if (in_tx) begin
                    check("mem_enable_busy", mem_enable, 1);
                    check("mem_cmd", mem_cmd, e_cmd);
                    check("mem_addr", mem_addr, e_addr);
                    check("mem_mask", mem_mask, e_mask);
                    check("mem_write_data", mem_write_data, e_wd);
                    if (wait_n == 0) begin
                        rd = use_force_data ? force_data : $urandom;
                        mem_valid = 1'b1;
                        mem_load_data = rd;
                        e.port_dm = own_dm;
                        e.rdata = rd;
                        e.due = cyc + 1;
                        sb.push_back(e);
                        in_tx = 0;
                    end else begin
                        mem_valid = 1'b0;
                        wait_n--;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a completion pulse appears
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check("valid_exclusive", if_valid && dm_valid, 0);
            check("enable_valid_overlap", mem_enable && (if_valid || dm_valid), 0);
            if (if_valid || dm_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", {if_valid, dm_valid}, 0);
                end else begin
                    e = sb.pop_front();
                    check("valid_port", dm_valid, e.port_dm);
                    check("valid_cycle", cyc, e.due);
                    if (e.port_dm) begin
                        model_dm_rd = e.rdata;
                        check("dm_rdata", dm_rdata, model_dm_rd);
                        check("if_rdata_held", if_rdata, model_if_rd);
                    end else begin
                        model_if_rd = e.rdata;
                        check("if_rdata", if_rdata, model_if_rd);
                        check("dm_rdata_held", dm_rdata, model_dm_rd);
                    end
                end
            end
        end
    end

    // Caller must be positioned just after a rising edge
    task automatic do_req(input bit dm, input int gap, input logic [31:0] addr,
                          input logic cmd, input logic [3:0] mask, input logic [31:0] wd);
        bit seen;
        int n;
        repeat (gap) begin @(posedge clk); #1; end
        if (dm) begin
            d_addr = addr; d_cmd = cmd; d_mask = mask; d_wdata = wd;
            dm_addr = addr; dm_cmd = cmd; dm_mask = mask; dm_wdata = wd;
            d_raise = cyc; d_pend = 1; dm_req = 1'b1;
        end else begin
            f_addr = addr; if_addr = addr;
            f_raise = cyc; f_pend = 1; if_req = 1'b1;
        end
        seen = 0;
        n = 0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            seen = dm ? (dm_valid === 1'b1) : (if_valid === 1'b1);
            n++;
        end
        if (!seen) check(dm ? "dm_timeout" : "if_timeout", 0, 1);
        @(posedge clk); #1;
        if (dm) begin dm_req = 1'b0; d_pend = 0; end
        else begin if_req = 1'b0; f_pend = 0; end
    endtask

    task automatic rand_port(input bit dm, input int n);
        for (int i = 0; i < n; i++) begin
            do_req(dm, $urandom_range(0, 4), $urandom & 32'hFFFF_FFFC,
                   dm ? 1'($urandom) : 1'b0, dm ? 4'($urandom) : 4'hF, dm ? $urandom : 32'h0);
        end
    endtask

    initial begin
        int n;
        reset_n = 0;
        if_req = 0; if_addr = '0;
        dm_req = 0; dm_cmd = 0; dm_addr = '0; dm_mask = '0; dm_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_enable", mem_enable, 0);
        check("rst_mem_cmd", mem_cmd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_mask", mem_mask, 0);
        check("rst_mem_write_data", mem_write_data, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_dm_valid", dm_valid, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        @(posedge clk); #1;
        reset_n = 1;
        mon_en = 1;
        resp_en = 1;

        force_lat = 2; use_force_data = 1; force_data = 32'h0000_0100;
        do_req(0, 0, 32'h14, 1'b0, 4'hF, 32'h0);
        check("fetch_rdata_final", if_rdata, 32'h0000_0100);

        force_lat = 1; force_data = 32'hDEAD_BEEF;
        do_req(1, 0, 32'h14, 1'b1, 4'b0011, 32'h0000_FFFF);
        use_force_data = 0;

        // Both ports re-raise immediately with zero memory latency
        force_lat = 0; chk_period = 1; last_grant = -1;
        fork
            for (int i = 0; i < 4; i++) do_req(1, 0, 32'h100 + 32'(i * 4), 1'b0, 4'hF, 32'h0);
            for (int i = 0; i < 4; i++) do_req(0, 0, 32'h200 + 32'(i * 4), 1'b0, 4'hF, 32'h0);
        join
        chk_period = 0; force_lat = -1;

        fork
            rand_port(1, 30);
            rand_port(0, 30);
        join

        // Reset while the memory never answers
        resp_en = 0;
        mem_valid = 0;
        dm_addr = 32'h40; dm_cmd = 0; dm_mask = 4'hF; dm_req = 1;
        n = 0;
        while (mem_enable !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("midrst_busy_seen", mem_enable, 1);
        @(negedge clk);
        reset_n = 0;
        @(posedge clk); #1;
        reset_n = 1;
        dm_req = 0;
        model_last_dm = 0; model_if_rd = '0; model_dm_rd = '0;
        @(negedge clk);
        check("midrst_mem_enable", mem_enable, 0);
        check("midrst_dm_valid", dm_valid, 0);
        check("midrst_dm_rdata", dm_rdata, 0);
        mem_valid = 1;
        mem_load_data = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stray_mem_enable", mem_enable, 0);
            check("stray_if_valid", if_valid, 0);
            check("stray_dm_valid", dm_valid, 0);
        end
        mem_valid = 0;
        @(posedge clk); #1;
        resp_en = 1;

        fork
            rand_port(1, 10);
            rand_port(0, 10);
        join

        repeat (10) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
